s_div_iter_unit: RTL and testbench

- Iterative radix-2 signed/unsigned integer divider for the streaming PEA.
- Acts as the responder side of the PE-to-FU handshake. A streaming PE issues operands with a valid. This block accepts them when ready and returns quotient and remainder together with a valid.
- It honours the array-wide stall (pea_ready_i) and the PE NOP clear.
- One restoring-division step per cycle.

---
 rtl/s_div_iter_unit_pkg.sv | 27 ++
 rtl/s_div_iter_unit_step.sv | 35 +++
 rtl/s_div_iter_unit.sv | 156 +++++++++++++++
 tb/tb_s_div_iter_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/s_div_iter_unit_pkg.sv
// -----------------------------------------------------------------------------
// s_div_iter_unit_pkg
// Shared types and constants for the iterative integer divider.
//   div_state_t : divider control states
//   DIV_N_BITS  : default operand/result width
//   DIV_LAT     : accept-to-valid latency on the normal (iterative) path,
//                 counting the accept edge as the first edge
// -----------------------------------------------------------------------------
package s_div_iter_unit_pkg;

  localparam int DIV_N_BITS = 32;

  function automatic int div_lat(input int n_bits);
    // accept edge + one edge per quotient bit + sign fix-up edge
    return n_bits + 2;
  endfunction

  localparam int DIV_LAT = div_lat(DIV_N_BITS);

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/s_div_iter_unit_step.sv
// -----------------------------------------------------------------------------
// s_div_iter_unit_step
// One radix-2 restoring-division step (purely combinational). Kept separate so
// a higher-radix step can be dropped in without touching the control logic.
//   rem_i  : partial remainder (always < div_i on entry)
//   quot_i : dividend/quotient shift register
//   div_i  : divisor magnitude
//   rem_o  : next partial remainder
//   quot_o : next quotient shift register (new quotient bit in LSB)
// -----------------------------------------------------------------------------
module s_div_iter_unit_step #(
  parameter int N_BITS = 32
) (
  input  logic [N_BITS-1:0] rem_i,
  input  logic [N_BITS-1:0] quot_i,
  input  logic [N_BITS-1:0] div_i,
  output logic [N_BITS-1:0] rem_o,
  output logic [N_BITS-1:0] quot_o
);

  logic [N_BITS:0]   shifted;
  logic              borrow;
  logic [N_BITS-1:0] diff;

  always_comb begin
    // {rem,quot} << 1 : the dividend MSB moves into the remainder
    shifted = {rem_i, quot_i[N_BITS-1]};
    borrow  = (shifted < {1'b0, div_i});
    // When no borrow the true difference is < div_i, so N_BITS bits suffice
    diff    = shifted[N_BITS-1:0] - div_i;
    quot_o  = {quot_i[N_BITS-2:0], ~borrow};
    rem_o   = borrow ? shifted[N_BITS-1:0] : diff;
  end

endmodule

// File: rtl/s_div_iter_unit.sv
// -----------------------------------------------------------------------------
// s_div_iter_unit
// Iterative radix-2 signed/unsigned integer divider, responder side of the
// PE-to-FU handshake. One restoring step per cycle, then a one-cycle sign
// fix-up, then the result is held until the array consumes it.
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   a_i, b_i       : dividend, divisor (sampled only on accept)
//   signed_i       : 1 = two's-complement operands, 0 = unsigned
//   ops_valid_i    : operands valid
//   clear_i        : synchronous abort, highest priority in every state
//   pea_ready_i    : array-level ready; only gates leaving DONE
//   ready_o        : block can accept operands this cycle
//   valid_o        : quot_o/rem_o hold a result
//   quot_o, rem_o  : quotient (truncated toward zero), remainder (sign of a)
//   busy_o         : operation in flight
// -----------------------------------------------------------------------------
module s_div_iter_unit
  import s_div_iter_unit_pkg::*;
#(
  parameter int N_BITS = DIV_N_BITS
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [N_BITS-1:0] a_i,
  input  logic [N_BITS-1:0] b_i,
  input  logic              signed_i,
  input  logic              ops_valid_i,
  input  logic              clear_i,
  input  logic              pea_ready_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [N_BITS-1:0] quot_o,
  output logic [N_BITS-1:0] rem_o,
  output logic              busy_o
);

  localparam int                CNT_W    = $clog2(N_BITS);
  localparam logic [N_BITS-1:0] MIN_NEG  = {1'b1, {(N_BITS-1){1'b0}}};
  localparam logic [N_BITS-1:0] ALL_ONES = '1;

  div_state_t        state_q;
  logic              valid_q;
  logic              neg_quot_q;
  logic              neg_rem_q;
  logic [N_BITS-1:0] quot_q;
  logic [N_BITS-1:0] rem_q;
  logic [N_BITS-1:0] div_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [N_BITS-1:0] rem_d;
  logic [N_BITS-1:0] quot_d;

  logic              a_neg;
  logic              b_neg;
  logic              accept;
  logic              div_zero;
  logic              overflow;

  // Conditional two's-complement negation, used for magnitudes and fix-up
  function automatic logic [N_BITS-1:0] cond_neg(input logic [N_BITS-1:0] v,
                                                 input logic              neg);
    return neg ? (~v + {{(N_BITS-1){1'b0}}, 1'b1}) : v;
  endfunction

  assign a_neg    = signed_i & a_i[N_BITS-1];
  assign b_neg    = signed_i & b_i[N_BITS-1];
  assign ready_o  = (state_q == DIV_IDLE) || ((state_q == DIV_DONE) && pea_ready_i);
  assign accept   = ops_valid_i && ready_o && !clear_i;
  assign div_zero = (b_i == '0);
  // MIN_NEG / -1 is the only signed quotient that does not fit
  assign overflow = signed_i && (a_i == MIN_NEG) && (b_i == ALL_ONES);

  s_div_iter_unit_step #(
    .N_BITS (N_BITS)
  ) u_step (
    .rem_i  (rem_q),
    .quot_i (quot_q),
    .div_i  (div_q),
    .rem_o  (rem_d),
    .quot_o (quot_d)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= DIV_IDLE;
      valid_q    <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      div_q      <= '0;
      cnt_q      <= '0;
    end else if (clear_i) begin
      // Abort: data registers are left as-is, only control returns to IDLE
      state_q <= DIV_IDLE;
      valid_q <= 1'b0;
    end else if (accept) begin
      // Accept is only possible from IDLE or a consumed DONE (back-to-back)
      neg_quot_q <= a_neg ^ b_neg;
      neg_rem_q  <= a_neg;
      div_q      <= cond_neg(b_i, b_neg);
      cnt_q      <= CNT_W'(N_BITS - 1);
      if (div_zero) begin
        state_q <= DIV_DONE;
        valid_q <= 1'b1;
        quot_q  <= ALL_ONES;
        rem_q   <= a_i;
      end else if (overflow) begin
        state_q <= DIV_DONE;
        valid_q <= 1'b1;
        quot_q  <= MIN_NEG;
        rem_q   <= '0;
      end else begin
        state_q <= DIV_CALC;
        valid_q <= 1'b0;
        quot_q  <= cond_neg(a_i, a_neg);
        rem_q   <= '0;
      end
    end else begin
      case (state_q)
        DIV_CALC: begin
          rem_q  <= rem_d;
          quot_q <= quot_d;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            state_q <= DIV_FIX;
          end
        end
        DIV_FIX: begin
          quot_q  <= cond_neg(quot_q, neg_quot_q);
          rem_q   <= cond_neg(rem_q, neg_rem_q);
          state_q <= DIV_DONE;
          valid_q <= 1'b1;
        end
        DIV_DONE: begin
          // Result consumed with no new operands: drop back to IDLE
          if (pea_ready_i) begin
            state_q <= DIV_IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= DIV_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign valid_o = valid_q;
  assign quot_o  = quot_q;
  assign rem_o   = rem_q;
  assign busy_o  = (state_q != DIV_IDLE);

endmodule

// File: tb/tb_s_div_iter_unit.sv
// -----------------------------------------------------------------------------
// tb_s_div_iter_unit
// Scoreboard bench: the driver pushes hand-computed expectations when an
// operand set is accepted; a monitor pops and compares when valid_o appears,
// and checks hold stability and ready_o while a result is presented.
// -----------------------------------------------------------------------------
module tb_s_div_iter_unit;
  import s_div_iter_unit_pkg::*;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] a_i;
  logic [N-1:0] b_i;
  logic         signed_i;
  logic         ops_valid_i;
  logic         clear_i;
  logic         pea_ready_i;
  logic         ready_o;
  logic         valid_o;
  logic [N-1:0] quot_o;
  logic [N-1:0] rem_o;
  logic         busy_o;

  always #5 clk = ~clk;

  s_div_iter_unit #(
    .N_BITS (N)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .a_i         (a_i),
    .b_i         (b_i),
    .signed_i    (signed_i),
    .ops_valid_i (ops_valid_i),
    .clear_i     (clear_i),
    .pea_ready_i (pea_ready_i),
    .ready_o     (ready_o),
    .valid_o     (valid_o),
    .quot_o      (quot_o),
    .rem_o       (rem_o),
    .busy_o      (busy_o)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } vec_t;

  exp_t        exp_q[$];
  exp_t        cur;
  bit          have = 1'b0;
  logic [31:0] held_q;
  logic [31:0] held_r;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, expv, cyc);
  endtask

  // Monitor: samples after the driver's negedge updates, i.e. the values the
  // next rising edge will see.
  always begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      have = 1'b0;
    end else if (valid_o) begin
      if (!have) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_valid: valid_o=1 with no pending operation (cycle %0d)", cyc);
        end else begin
          cur  = exp_q.pop_front();
          have = 1'b1;
          check("latency", 32'(cyc - cur.acc + 1), 32'(cur.lat));
          check("quot", quot_o, cur.q);
          check("rem", rem_o, cur.r);
          held_q = quot_o;
          held_r = rem_o;
        end
      end else begin
        check("hold_quot", quot_o, held_q);
        check("hold_rem", rem_o, held_r);
      end
      check("ready_in_done", 32'(ready_o), 32'(pea_ready_i));
      if (pea_ready_i) have = 1'b0;
    end else if (busy_o) begin
      check("ready_while_busy", 32'(ready_o), 32'd0);
    end
  end

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [31:0] eq, input logic [31:0] er, input int lat);
    exp_t e;
    int   waited = 0;
    a_i = a; b_i = b; signed_i = s; ops_valid_i = 1'b1;
    #1;
    while (!(ready_o && !clear_i) && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (waited >= 200) begin
      n_checks++;
      $display("FAIL accept_timeout: ready_o stayed 0 for a=0x%08h b=0x%08h", a, b);
      ops_valid_i = 1'b0;
    end else begin
      e.q = eq; e.r = er; e.lat = lat; e.acc = cyc + 1;
      exp_q.push_back(e);
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((exp_q.size() != 0 || have || busy_o) && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) begin
      n_checks++;
      $display("FAIL idle_timeout: pending=%0d busy_o=%0b", exp_q.size(), busy_o);
    end
  endtask

  vec_t vecs[14] = '{
    '{32'd100,      32'd7,        1'b1, 32'd14,       32'd2,        DIV_LAT},
    '{32'hFFFFFF9C, 32'd7,        1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, DIV_LAT},
    '{32'd100,      32'hFFFFFFF9, 1'b1, 32'hFFFFFFF2, 32'd2,        DIV_LAT},
    '{32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 32'd14,       32'hFFFFFFFE, DIV_LAT},
    '{32'd5,        32'd0,        1'b0, 32'hFFFFFFFF, 32'd5,        1},
    '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0,        1},
    '{32'hFFFFFFFF, 32'd2,        1'b0, 32'h7FFFFFFF, 32'd1,        DIV_LAT},
    '{32'hFFFFFFFF, 32'd2,        1'b1, 32'd0,        32'hFFFFFFFF, DIV_LAT},
    '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0,        32'h80000000, DIV_LAT},
    '{32'hFFFFFFFB, 32'd0,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFFB, 1},
    '{32'd0,        32'd3,        1'b1, 32'd0,        32'd0,        DIV_LAT},
    '{32'd7,        32'd7,        1'b0, 32'd1,        32'd0,        DIV_LAT},
    '{32'h80000000, 32'd1,        1'b1, 32'h80000000, 32'd0,        DIV_LAT},
    '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd1,        32'd0,        DIV_LAT}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; a_i = '0; b_i = '0; signed_i = 1'b0;
    ops_valid_i = 1'b0; clear_i = 1'b0; pea_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_quot", quot_o, 32'd0);
    check("rst_rem", rem_o, 32'd0);
    rst_n = 1'b1;

    // Main vectors, issued back-to-back
    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].q, vecs[i].r, vecs[i].lat);
    end
    ops_valid_i = 1'b0;
    wait_idle();

    // Stall: array not ready from edge 30 to edge 40, next operands waiting
    issue(32'd100, 32'd7, 1'b1, 32'd14, 32'd2, DIV_LAT);
    fork
      begin
        repeat (28) @(negedge clk);
        pea_ready_i = 1'b0;
        repeat (10) @(negedge clk);
        pea_ready_i = 1'b1;
      end
      begin
        issue(32'd1000, 32'hFFFFFFDF, 1'b1, 32'hFFFFFFE2, 32'd10, DIV_LAT);
      end
    join
    ops_valid_i = 1'b0;
    wait_idle();

    // Clear pulse on edge 10 of the operation
    issue(32'd100, 32'd7, 1'b1, 32'd14, 32'd2, DIV_LAT);
    ops_valid_i = 1'b0;
    repeat (8) @(negedge clk);
    clear_i = 1'b1;
    exp_q.delete();
    @(negedge clk);
    clear_i = 1'b0;
    check("clear_ready", 32'(ready_o), 32'd1);
    check("clear_busy", 32'(busy_o), 32'd0);
    check("clear_valid", 32'(valid_o), 32'd0);
    repeat (40) @(negedge clk);

    // Asynchronous reset in the middle of an operation
    issue(32'd12345, 32'd11, 1'b0, 32'd1122, 32'd3, DIV_LAT);
    ops_valid_i = 1'b0;
    repeat (5) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(ready_o), 32'd1);
    check("arst_valid", 32'(valid_o), 32'd0);
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_quot", quot_o, 32'd0);
    check("arst_rem", rem_o, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Normal operation after reset
    issue(32'd12345, 32'd11, 1'b0, 32'd1122, 32'd3, DIV_LAT);
    ops_valid_i = 1'b0;
    wait_idle();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
